// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS core: ALU, HI/LO with single-cycle multiply
// and a restoring divider, data SRAM request and forwarding back to decode.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  input  logic [4:0]              id_mem_op,
  output logic                    stallreq_for_ex,
  output logic                    ex_we,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic [4:0]              ex_ram_ctrl,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  logic [ID_TO_EX_WD-1:0] bus_reg;
  logic [4:0]             mem_op_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_reg    <= '0;
      mem_op_reg <= '0;
    end else if (stall[2] && !stall[3]) begin
      bus_reg    <= '0;
      mem_op_reg <= '0;
    end else if (!stall[2]) begin
      bus_reg    <= id_to_ex_bus;
      mem_op_reg <= id_mem_op;
    end
  end

  logic [31:0] pc, inst, rs_val, rt_val;
  logic [11:0] alu_op;
  logic [2:0]  src1;
  logic [3:0]  src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign pc         = bus_reg[158:127];
  assign inst       = bus_reg[126:95];
  assign alu_op     = bus_reg[94:83];
  assign src1       = bus_reg[82:80];
  assign src2       = bus_reg[79:76];
  assign ram_en     = bus_reg[75];
  assign ram_wen    = bus_reg[74:71];
  assign rf_we      = bus_reg[70];
  assign rf_waddr   = bus_reg[69:65];
  assign sel_rf_res = bus_reg[64];
  assign rs_val     = bus_reg[63:32];
  assign rt_val     = bus_reg[31:0];

  logic [5:0] opcode, funct;
  logic       special;
  logic       is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu;
  logic       is_div, is_divu, div_any, is_mul, is_sb, is_sh, is_sw;

  assign opcode   = inst[31:26];
  assign funct    = inst[5:0];
  assign special  = (opcode == 6'b000000);
  assign is_mfhi  = special && (funct == 6'b010000);
  assign is_mthi  = special && (funct == 6'b010001);
  assign is_mflo  = special && (funct == 6'b010010);
  assign is_mtlo  = special && (funct == 6'b010011);
  assign is_mult  = special && (funct == 6'b011000);
  assign is_multu = special && (funct == 6'b011001);
  assign is_div   = special && (funct == 6'b011010);
  assign is_divu  = special && (funct == 6'b011011);
  assign div_any  = is_div || is_divu;
  assign is_mul   = (opcode == 6'b011100) && (funct == 6'b000010);
  assign is_sb    = (opcode == 6'b101000);
  assign is_sh    = (opcode == 6'b101001);
  assign is_sw    = (opcode == 6'b101011);

  logic [31:0] op1, op2, sum, diff, alu_res;
  logic [4:0]  shamt;

  assign op1 = ({32{src1[0]}} & rs_val)
             | ({32{src1[1]}} & pc)
             | ({32{src1[2]}} & {27'b0, inst[10:6]});
  assign op2 = ({32{src2[0]}} & rt_val)
             | ({32{src2[1]}} & {{16{inst[15]}}, inst[15:0]})
             | ({32{src2[2]}} & 32'd8)
             | ({32{src2[3]}} & {16'b0, inst[15:0]});
  assign sum   = op1 + op2;
  assign diff  = op1 - op2;
  assign shamt = op1[4:0];

  // alu_op is one-hot, so the selected results can simply be OR-ed together
  always_comb begin
    alu_res = '0;
    if (alu_op[11]) alu_res |= sum;
    if (alu_op[10]) alu_res |= diff;
    if (alu_op[9])  alu_res |= {31'b0, $signed(op1) < $signed(op2)};
    if (alu_op[8])  alu_res |= {31'b0, op1 < op2};
    if (alu_op[7])  alu_res |= op1 & op2;
    if (alu_op[6])  alu_res |= ~(op1 | op2);
    if (alu_op[5])  alu_res |= op1 | op2;
    if (alu_op[4])  alu_res |= op1 ^ op2;
    if (alu_op[3])  alu_res |= op2 << shamt;
    if (alu_op[2])  alu_res |= op2 >> shamt;
    if (alu_op[1])  alu_res |= $unsigned($signed(op2) >>> shamt);
    if (alu_op[0])  alu_res |= {op2[15:0], 16'b0};
  end

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Divider: quo_reg doubles as the dividend shift register
  div_state_t  state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [31:0] quo_reg, dvs_reg, rem_reg;
  logic        q_neg_reg, r_neg_reg, dz_reg;
  logic        div_start, div_step, div_finish;
  logic [32:0] rem_shift, rem_try, rem_step;
  logic        rem_ge;
  logic [31:0] quo_step, quo_fix, rem_fix;

  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_reg});
  assign rem_try   = rem_shift - {1'b0, dvs_reg};
  assign rem_step  = rem_ge ? rem_try : rem_shift;
  assign quo_step  = {quo_reg[30:0], rem_ge};
  // on divide-by-zero the remainder walks back to |rs|, so the sign fix restores rs_val
  assign quo_fix   = dz_reg ? 32'hFFFF_FFFF : (q_neg_reg ? -quo_step : quo_step);
  assign rem_fix   = r_neg_reg ? -rem_step[31:0] : rem_step[31:0];

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    div_step   = 1'b0;
    div_finish = 1'b0;
    case (state_reg)
      DIV_IDLE: begin
        if (div_any) begin
          state_next = DIV_CALC;
          div_start  = 1'b1;
        end
      end
      DIV_CALC: begin
        div_step = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          div_finish = 1'b1;
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (!stall[2]) state_next = DIV_IDLE;
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (div_start) begin
        cnt_reg   <= '0;
        rem_reg   <= '0;
        quo_reg   <= (is_div && rs_val[31]) ? -rs_val : rs_val;
        dvs_reg   <= (is_div && rt_val[31]) ? -rt_val : rt_val;
        q_neg_reg <= is_div && (rs_val[31] ^ rt_val[31]);
        r_neg_reg <= is_div && rs_val[31];
        dz_reg    <= (rt_val == 32'd0);
      end else if (div_step) begin
        cnt_reg <= cnt_reg + 5'd1;
        quo_reg <= quo_step;
        rem_reg <= rem_step[31:0];
      end
    end
  end

  logic [31:0] hi_reg, lo_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (div_finish) begin
      hi_reg <= rem_fix;
      lo_reg <= quo_fix;
    end else if (!stall[2]) begin
      if (is_mthi)  hi_reg <= rs_val;
      if (is_mtlo)  lo_reg <= rs_val;
      if (is_mult)  {hi_reg, lo_reg} <= prod_s;
      if (is_multu) {hi_reg, lo_reg} <= prod_u;
    end
  end

  logic [31:0] result;
  assign result = is_mfhi ? hi_reg :
                  is_mflo ? lo_reg :
                  is_mul  ? prod_s[31:0] : alu_res;

  assign stallreq_for_ex = div_any && ((state_reg == DIV_IDLE) || (state_reg == DIV_CALC));
  assign ex_we           = rf_we;
  assign ex_waddr        = rf_waddr;
  assign ex_wdata        = result;
  assign ex_ram_ctrl     = mem_op_reg;
  assign data_sram_en    = ram_en;
  assign data_sram_addr  = sum;
  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, result};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign data_sram_wen[gi] = ram_en & (is_sw
                               | (is_sh & (sum[1] == LANE[1]))
                               | (is_sb & (sum[1:0] == LANE)));
      assign data_sram_wdata[8*gi +: 8] = is_sw ? rt_val[8*gi +: 8] :
                                          is_sh ? rt_val[8*(gi%2) +: 8] : rt_val[7:0];
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0], rem_step[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, stores, HI/LO multiply/divide, reset and bubble.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [158:0] id_to_ex_bus;
  logic [4:0]  id_mem_op;
  logic        stallreq_for_ex, ex_we, data_sram_en;
  logic [4:0]  ex_waddr, ex_ram_ctrl;
  logic [31:0] ex_wdata, data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wen;
  logic [75:0] ex_to_mem_bus;

  int passed = 0;
  int total  = 0;
  int cyc;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus), .id_mem_op(id_mem_op),
    .stallreq_for_ex(stallreq_for_ex), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_ram_ctrl(ex_ram_ctrl), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .ex_to_mem_bus(ex_to_mem_bus)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] SRA = 12'h002, LUI = 12'h001, NONE = 12'h000;

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] alu, input logic [2:0] s1, input logic [3:0] s2,
                                      input logic en, input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, alu, s1, s2, en, wen, we, wa, sel, rs, rt};
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [158:0] b, input logic [4:0] m);
    id_to_ex_bus = b;
    id_mem_op    = m;
    stall        = 6'b000000;
    step();
    $display("issue inst=%h -> wdata=%h wen=%b addr=%h", b[126:95], ex_wdata, data_sram_wen, data_sram_addr);
  endtask

  // Issue a divide, then keep the stage stalled while it requests; returns the busy cycle count
  task automatic run_div(input logic [158:0] b, output int busy);
    issue(b, 5'd0);
    busy = 0;
    while (stallreq_for_ex && busy < 100) begin
      busy++;
      stall = 6'b001111;
      step();
    end
    stall = 6'b000000;
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b0;
    id_to_ex_bus = '0;
    id_mem_op = '0;
    #1;
    chk("reset_bus", ex_to_mem_bus, 76'd0);
    chk("reset_stallreq", stallreq_for_ex, 1'b0);
    chk("reset_sram", {data_sram_en, data_sram_wen}, 5'd0);
    step();
    rst = 1'b0;

    // addiu wraps with no trap
    issue(mk(32'h100, 32'h24220001, ADD, 3'b001, 4'b0010, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h7FFFFFFF, 32'h0), 5'd0);
    chk("addiu_bus", ex_to_mem_bus, {32'h100, 1'b0, 4'b0, 1'b0, 1'b1, 5'd2, 32'h80000000});
    chk("addiu_fwd", {ex_we, ex_waddr, ex_wdata}, {1'b1, 5'd2, 32'h80000000});
    chk("addiu_sram_en", data_sram_en, 1'b0);

    // stall with next stage stalled too holds the register
    id_to_ex_bus = mk(32'h104, 32'h00221023, SUB, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7);
    stall = 6'b001111;
    step();
    chk("hold", ex_wdata, 32'h80000000);

    issue(mk(32'h104, 32'h00221023, SUB, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7), 5'd0);
    chk("subu", ex_wdata, 32'hFFFFFFFE);
    issue(mk(32'h108, 32'h0022102A, SLT, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'hFFFFFFFF, 32'd1), 5'd0);
    chk("slt", ex_wdata, 32'd1);
    issue(mk(32'h10C, 32'h0022102B, SLTU, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'hFFFFFFFF, 32'd1), 5'd0);
    chk("sltu", ex_wdata, 32'd0);
    issue(mk(32'h110, 32'h00021103, SRA, 3'b100, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h80000000), 5'd0);
    chk("sra", ex_wdata, 32'hF8000000);
    issue(mk(32'h114, 32'h3C021234, LUI, 3'b000, 4'b1000, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("lui", ex_wdata, 32'h12340000);

    // stores and a load
    issue(mk(32'h118, 32'hA0230003, ADD, 3'b001, 4'b0010, 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h1000, 32'h12345678), 5'd0);
    chk("sb_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, {1'b1, 4'b1000, 32'h1003, 32'h78787878});
    issue(mk(32'h11C, 32'hA4230002, ADD, 3'b001, 4'b0010, 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0, 32'h1000, 32'h12345678), 5'd0);
    chk("sh_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, {1'b1, 4'b1100, 32'h1002, 32'h56785678});
    issue(mk(32'h120, 32'hAC230000, ADD, 3'b001, 4'b0010, 1'b1, 4'b1111, 1'b0, 5'd0, 1'b0, 32'h1000, 32'h12345678), 5'd0);
    chk("sw_req", {data_sram_wen, data_sram_wdata}, {4'b1111, 32'h12345678});
    issue(mk(32'h124, 32'h8C230004, ADD, 3'b001, 4'b0010, 1'b1, 4'b0000, 1'b1, 5'd3, 1'b1, 32'h1000, 32'h0), 5'b00001);
    chk("lw_req", {data_sram_en, data_sram_wen, data_sram_addr, ex_ram_ctrl}, {1'b1, 4'b0000, 32'h1004, 5'b00001});

    // multiply
    issue(mk(32'h128, 32'h00220019, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd2), 5'd0);
    issue(mk(32'h12C, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("multu_hi", ex_wdata, 32'h00000001);
    issue(mk(32'h130, 32'h00001012, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("multu_lo", ex_wdata, 32'hFFFFFFFE);
    issue(mk(32'h134, 32'h00220018, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'd2), 5'd0);
    issue(mk(32'h138, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("mult_hi", ex_wdata, 32'hFFFFFFFF);
    issue(mk(32'h13C, 32'h00001012, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("mult_lo", ex_wdata, 32'hFFFFFFFE);
    issue(mk(32'h140, 32'h70221002, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'd3, 32'd7), 5'd0);
    chk("mul", ex_wdata, 32'd21);

    // signed divide -7 / 2
    run_div(mk(32'h144, 32'h0022001A, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFF9, 32'd2), cyc);
    chk("div_busy_cycles", cyc, 33);
    issue(mk(32'h148, 32'h00001012, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("div_lo", ex_wdata, 32'hFFFFFFFD);
    issue(mk(32'h14C, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("div_hi", ex_wdata, 32'hFFFFFFFF);

    // unsigned divide by zero
    run_div(mk(32'h150, 32'h0022001B, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'd5, 32'd0), cyc);
    chk("divu0_busy_cycles", cyc, 33);
    issue(mk(32'h154, 32'h00001012, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("divu0_lo", ex_wdata, 32'hFFFFFFFF);
    issue(mk(32'h158, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("divu0_hi", ex_wdata, 32'd5);

    // mthi, then reset in the middle of a division
    issue(mk(32'h15C, 32'h00200011, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'hCAFEBABE, 32'h0), 5'd0);
    issue(mk(32'h160, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("mthi", ex_wdata, 32'hCAFEBABE);
    issue(mk(32'h164, 32'h0022001B, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7), 5'd0);
    for (int i = 0; i < 11; i++) begin
      stall = 6'b001111;
      step();
    end
    chk("div_midway_busy", stallreq_for_ex, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_bus", ex_to_mem_bus, 76'd0);
    id_to_ex_bus = '0;
    stall = 6'b000000;
    step();
    rst = 1'b0;
    issue(mk(32'h168, 32'h00001010, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("rst_hi", ex_wdata, 32'h0);
    issue(mk(32'h16C, 32'h00001012, NONE, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0), 5'd0);
    chk("rst_lo", ex_wdata, 32'h0);
    chk("rst_no_restall", stallreq_for_ex, 1'b0);

    // bubble: this stage stalled, next stage free
    issue(mk(32'h170, 32'hA0230003, ADD, 3'b001, 4'b0010, 1'b1, 4'b0001, 1'b1, 5'd4, 1'b0, 32'h1000, 32'h12345678), 5'b00010);
    chk("pre_bubble_en", data_sram_en, 1'b1);
    stall = 6'b000111;
    step();
    chk("bubble_bus", ex_to_mem_bus, 76'd0);
    chk("bubble_sram", {data_sram_en, data_sram_wen, ex_we, ex_ram_ctrl}, 11'd0);
    stall = 6'b000000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS core. It sits directly downstream of the decode stage and upstream of the memory stage.
- It registers the 159-bit decode-to-execute bus and computes the ALU result.
- It owns the HI/LO registers, with a single-cycle mult/multu/mul and a 32-iteration radix-2 divider for div/divu.
- It issues the data-SRAM request, drives the forwarding/hazard signals back to decode, and asserts a stall request while the divider runs.

Parameters:
- ID_TO_EX_WD, 159, width of the incoming decode bus
- EX_TO_MEM_WD, 76, width of the outgoing bus
- DIV_CYCLES, 32, divider iteration count

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 2 = this stage, bit 3 = next stage; 1 = Stop
- id_to_ex_bus  in  159  fields:
  - {pc[158:127], inst[126:95], alu_op[94:83], src1[82:80], src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_val[63:32], rt_val[31:0]}
  - alu_op = {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}
- id_mem_op  in  5  {lb, lbu, lh, lhu, lw}, registered alongside the bus
- stallreq_for_ex  out  1  divider busy
- ex_we, ex_waddr, ex_wdata  out  1/5/32  forwarding to decode
- ex_ram_ctrl  out  5  registered id_mem_op, used for load-use detection
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  data SRAM byte write enables
- data_sram_addr  out  32  data SRAM address
- data_sram_wdata  out  32  data SRAM write data
- ex_to_mem_bus  out  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], result[31:0]}

Behaviour:

Pipeline register
- Async reset clears it to zero.
- On each clk edge:
  - if stall[2]=1 and stall[3]=0, load zero (bubble);
  - else if stall[2]=0, load id_to_ex_bus and id_mem_op;
  - else hold.
- All outputs are combinational from this register, so the register holding zero gives a NOP: no write, no SRAM enable.

Operands
- src1:
  - bit0 selects rs_val
  - bit1 selects pc
  - bit2 selects {27'b0, inst[10:6]}
- src2:
  - bit0 selects rt_val
  - bit1 selects sign-extended inst[15:0]
  - bit2 selects 32'd8
  - bit3 selects zero-extended inst[15:0]
- Shift amounts use src1[4:0] and shift src2.
- lui gives {src2[15:0], 16'b0}.
- add/sub wrap modulo 2^32; there is no overflow trap.

Result mux
- The result is the ALU output, except:
  - mfhi returns HI;
  - mflo returns LO;
  - mul returns product[31:0].
- mfhi, mflo, mthi, mtlo, mult, multu, div, divu and mul are decoded from the registered inst.

Forwarding
- ex_we = rf_we, ex_waddr = rf_waddr, ex_wdata = result.

Data SRAM request
- data_sram_en = ram_en; data_sram_addr = ALU sum.
- sw: wen = 4'b1111; wdata = rt_val.
- sh: wen = 4'b0011 when addr[1]=0, else 4'b1100; wdata = {2{rt_val[15:0]}}.
- sb: wen = 4'b0001 << addr[1:0]; wdata = {4{rt_val[7:0]}}.
- Load: wen = 0.

HI/LO registers
- Async reset sets both to zero.
- mthi writes HI and mtlo writes LO, each with rs_val.
- mult/multu write {HI, LO} with the signed/unsigned 64-bit product.
- Those writes happen on the edge where stall[2]=0.

Divider FSM (IDLE, CALC, DONE)
- IDLE:
  - When div/divu is present, go to CALC.
  - Latch |rs| and |rt| for signed, raw values for unsigned.
  - Latch the quotient and remainder signs.
  - Clear the counter.
- CALC:
  - One restoring shift-subtract step per cycle.
  - Counter runs 0..31; after the 32nd step, go to DONE.
- DONE:
  - Apply sign fixes; remainder takes the dividend sign.
  - Write LO = quotient and HI = remainder exactly once, on entry.
  - Hold in DONE until stall[2]=0, then return to IDLE.
- stallreq_for_ex = div present and state is IDLE or CALC.
  - It is therefore high for 33 cycles and low in DONE.
- Divisor zero: LO = 32'hFFFF_FFFF, HI = rs_val, no sign fix, same latency.
- Stall from another cause while in DONE: the result is held and the divider does not restart.
- Reset mid-division: FSM to IDLE, HI/LO cleared, stallreq deasserted immediately.
- A bubble loaded while in CALC cannot happen, because stallreq holds stall[2].

Test Plan:
1. addiu rs_val=0x7FFFFFFF, imm=0x0001 -> result 0x80000000; ex_we=1; no trap.
2. sb rt_val=0x12345678, addr=0x1003 -> wen=4'b1000, wdata=0x78787878; sh at 0x1002 -> wen=4'b1100, wdata=0x56785678.
3. div rs=-7, rt=2 -> stallreq high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; next mflo returns 0xFFFFFFFD.
4. divu rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5.
5. multu 0xFFFFFFFF × 2 -> HI=1, LO=0xFFFFFFFE; mult (-1)×2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
6. Reset:
   - Assert rst at CALC cycle 10 -> stallreq=0 and HI=LO=0 without waiting for a clock edge.
   - stall=6'b000111 with stall[3]=0 -> next cycle all outputs show a NOP.
